// File: rtl/rr_grant_arbiter8_if.sv
// rr_grant_arbiter8_if
//   Bundles the request side and the grant side of the 8-way round-robin
//   arbiter into one port.
//
//   Signal contract: each requester holds its req bit high for as long as it
//   wants the resource. The arbiter answers with a registered grant, one clock
//   after it samples a request. A requester owns the resource in every cycle
//   where its grant bit is high. Dropping req releases the grant at the next
//   edge. There is no separate ready signal: the grant is the acceptance.
//
//   Ports (via modports):
//     en          arbitration enable (master -> arbiter)
//     req[7:0]    request vector      (master -> arbiter)
//     grant[7:0]  one-hot grant       (arbiter -> master)
//     grant_idx   binary grant index  (arbiter -> master)
//     grant_valid grant is non-zero   (arbiter -> master)
//     expired     hold-limit pulse    (arbiter -> master)
interface rr_grant_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       expired;

  modport master (
    output en, req,
    input  grant, grant_idx, grant_valid, expired
  );

  modport slave (
    input  en, req,
    output grant, grant_idx, grant_valid, expired
  );
endinterface

// File: rtl/rr_grant_arbiter8.sv
// rr_grant_arbiter8
//   Round-robin arbiter that shares one resource among 8 requesters. It issues
//   a registered one-hot grant together with its binary index. A hold limit
//   (MAX_HOLD cycles) forces re-arbitration so that no requester can starve
//   the others.
//
//   Ports:
//     clk           system clock, rising edge
//     rst_n         asynchronous active-low reset
//     bus           rr_grant_arbiter8_if.slave (en, req, grant, grant_idx,
//                   grant_valid, expired)
//     dbg_state     current FSM state (0 = IDLE, 1 = GRANT)
//     dbg_hold_cnt  cycles the current grant has been held, minus one
//
//   Parameters:
//     MAX_HOLD  maximum consecutive cycles per grant, 1..256
//     CNT_W     hold counter width, 2**CNT_W >= MAX_HOLD
module rr_grant_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_grant_arbiter8_if.slave   bus,
  output logic                 dbg_state,
  output logic [CNT_W-1:0]     dbg_hold_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [7:0]       grant_q, grant_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Returns {found, index} of the first set bit of r, scanning r[start],
  // r[start+1], ... modulo 8. The loop runs from the farthest offset down to
  // offset 0, so the nearest set bit is the last one written and wins.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] k;
    logic [3:0] res;
    res = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      k = start + 3'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  logic [3:0] win_idle;
  logic [3:0] win_next;
  logic       releasing;
  logic       at_limit;

  assign win_idle  = pick(bus.req, last_q + 3'd1);
  // The scan starts just past the current owner and ends on it, so the owner
  // wins again only if it is the sole requester.
  assign win_next  = pick(bus.req, idx_q + 3'd1);
  assign releasing = ~bus.req[idx_q];
  assign at_limit  = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 8'h00;
      idx_q     <= 3'd0;
      last_q    <= 3'd7;
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.en && win_idle[3]) begin
          grant_d = 8'b1 << win_idle[2:0];
          idx_d   = win_idle[2:0];
          last_d  = win_idle[2:0];
          cnt_d   = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (!releasing && !at_limit) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // Release wins over expiry when both happen in the same cycle.
          expired_d = ~releasing;
          cnt_d     = '0;
          if (bus.en && win_next[3]) begin
            // Hand over at this same edge, with no idle gap.
            grant_d = 8'b1 << win_next[2:0];
            idx_d   = win_next[2:0];
            last_d  = win_next[2:0];
          end else begin
            grant_d = 8'h00;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = |grant_q;
  assign bus.expired     = expired_q;
  assign dbg_state       = (state_q == GRANT);
  assign dbg_hold_cnt    = cnt_q;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
module tb_rr_grant_arbiter8;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 8;
  // Observation vector: {grant, grant_idx, grant_valid, expired, state, hold_cnt}.
  localparam int W        = 8 + 3 + 1 + 1 + 1 + CNT_W;

  logic             clk;
  logic             rst_n;
  logic             dbg_state;
  logic [CNT_W-1:0] dbg_hold_cnt;

  rr_grant_arbiter8_if bus ();

  rr_grant_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_hold_cnt (dbg_hold_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  bit m_active;
  int m_idx;
  int m_last;
  int m_cnt;
  bit m_exp;

  function automatic void model_reset();
    m_active = 1'b0;
    m_idx    = 0;
    m_last   = 7;
    m_cnt    = 0;
    m_exp    = 1'b0;
  endfunction

  function automatic int m_pick(input int start);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = (start + i) % 8;
      if (bus.req[k]) return k;
    end
    return -1;
  endfunction

  // Advances the model by one clock edge, using the inputs as they stand now.
  function automatic void model_step();
    int w;
    bit pulse;
    pulse = 1'b0;
    if (!m_active) begin
      if (bus.en && bus.req != 8'h00) begin
        w        = m_pick((m_last + 1) % 8);
        m_active = 1'b1;
        m_idx    = w;
        m_last   = w;
        m_cnt    = 0;
      end
    end else if (bus.req[m_idx] && m_cnt != MAX_HOLD - 1) begin
      m_cnt = m_cnt + 1;
    end else begin
      pulse = bus.req[m_idx];
      m_cnt = 0;
      w     = bus.en ? m_pick((m_idx + 1) % 8) : -1;
      if (w >= 0) begin
        m_idx  = w;
        m_last = w;
      end else begin
        m_active = 1'b0;
      end
    end
    m_exp = pulse;
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [7:0] g;
    g = m_active ? (8'h01 << m_idx) : 8'h00;
    return {g, 3'(m_idx), m_active, m_exp, m_active, CNT_W'(m_cnt)};
  endfunction

  function automatic logic [W-1:0] observe();
    return {bus.grant, bus.grant_idx, bus.grant_valid, bus.expired, dbg_state, dbg_hold_cnt};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got;
  logic [W-1:0] exp_v;
  int vectors     = 0;
  int miscompares = 0;

  // Driver: push the expectation for the coming edge, then let it happen.
  task automatic tick();
    model_step();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    model_reset();
    #3;
    got   = observe();
    exp_v = '0;
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL reset_state got %h exp %h", got, exp_v);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_first_grant();
    bus.en  = 1'b1;
    bus.req = 8'h81;
    tick();
    got = observe(); exp_v = exp_q.pop_front(); vectors++;
    if (got !== exp_v) begin miscompares++; $display("FAIL first_grant sb got %h exp %h", got, exp_v); end
    vectors++;
    if (bus.grant !== 8'h01 || bus.grant_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL first_grant grant %h idx %0d exp 01 idx 0", bus.grant, bus.grant_idx);
    end
    bus.req = 8'h80;
    tick();
    got = observe(); exp_v = exp_q.pop_front(); vectors++;
    if (got !== exp_v) begin miscompares++; $display("FAIL handover sb got %h exp %h", got, exp_v); end
    vectors++;
    if (bus.grant !== 8'h80 || bus.grant_idx !== 3'd7) begin
      miscompares++;
      $display("FAIL handover grant %h idx %0d exp 80 idx 7", bus.grant, bus.grant_idx);
    end
    bus.req = 8'h00;
    tick();
    got = observe(); exp_v = exp_q.pop_front(); vectors++;
    if (got !== exp_v) begin miscompares++; $display("FAIL to_idle sb got %h exp %h", got, exp_v); end
  endtask

  task automatic test_rotation();
    int n_exp;
    logic [7:0] want;
    n_exp   = 0;
    bus.en  = 1'b1;
    bus.req = 8'hFF;
    for (int c = 1; c <= 36; c++) begin
      tick();
      got = observe(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin miscompares++; $display("FAIL rotation sb cyc %0d got %h exp %h", c, got, exp_v); end
      want = 8'h01 << (((c - 1) / MAX_HOLD) % 8);
      vectors++;
      if (bus.grant !== want) begin
        miscompares++;
        $display("FAIL rotation grant cyc %0d got %h exp %h", c, bus.grant, want);
      end
      if (bus.expired) n_exp++;
    end
    vectors++;
    if (n_exp != 8) begin
      miscompares++;
      $display("FAIL rotation expired_count got %0d exp 8", n_exp);
    end
    bus.req = 8'h00;
    tick();
    got = observe(); exp_v = exp_q.pop_front(); vectors++;
    if (got !== exp_v) begin miscompares++; $display("FAIL rotation idle sb got %h exp %h", got, exp_v); end
  endtask

  task automatic test_sole_expiry();
    int n_exp;
    n_exp   = 0;
    bus.en  = 1'b1;
    bus.req = 8'h10;
    for (int c = 1; c <= 13; c++) begin
      tick();
      got = observe(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin miscompares++; $display("FAIL sole sb cyc %0d got %h exp %h", c, got, exp_v); end
      vectors++;
      if (bus.grant !== 8'h10) begin
        miscompares++;
        $display("FAIL sole grant cyc %0d got %h exp 10", c, bus.grant);
      end
      if (bus.expired) n_exp++;
    end
    vectors++;
    if (n_exp != 3) begin
      miscompares++;
      $display("FAIL sole expired_count got %0d exp 3", n_exp);
    end
    bus.req = 8'h00;
    tick();
    got = observe(); exp_v = exp_q.pop_front(); vectors++;
    if (got !== exp_v) begin miscompares++; $display("FAIL sole idle sb got %h exp %h", got, exp_v); end
  endtask

  task automatic test_enable();
    bus.en  = 1'b0;
    bus.req = 8'h0F;
    for (int c = 0; c < 3; c++) begin
      tick();
      got = observe(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin miscompares++; $display("FAIL en_low sb got %h exp %h", got, exp_v); end
      vectors++;
      if (bus.grant !== 8'h00) begin miscompares++; $display("FAIL en_low grant got %h exp 00", bus.grant); end
    end
    bus.en = 1'b1;
    tick();
    got = observe(); exp_v = exp_q.pop_front(); vectors++;
    if (got !== exp_v) begin miscompares++; $display("FAIL en_rise sb got %h exp %h", got, exp_v); end
    vectors++;
    if (bus.grant !== 8'h01) begin miscompares++; $display("FAIL en_rise grant got %h exp 01", bus.grant); end
    bus.en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      got = observe(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin miscompares++; $display("FAIL en_hold sb got %h exp %h", got, exp_v); end
      vectors++;
      if (bus.grant !== 8'h01) begin miscompares++; $display("FAIL en_hold grant got %h exp 01", bus.grant); end
    end
    bus.req = 8'h0E;
    for (int c = 0; c < 2; c++) begin
      tick();
      got = observe(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin miscompares++; $display("FAIL en_drop sb got %h exp %h", got, exp_v); end
      vectors++;
      if (bus.grant !== 8'h00 || dbg_state !== 1'b0) begin
        miscompares++;
        $display("FAIL en_drop grant %h state %0b exp 00 state 0", bus.grant, dbg_state);
      end
    end
    bus.req = 8'h00;
  endtask

  task automatic test_async_reset();
    bus.en  = 1'b1;
    bus.req = 8'h04;
    tick();
    got = observe(); exp_v = exp_q.pop_front(); vectors++;
    if (got !== exp_v) begin miscompares++; $display("FAIL areset pre sb got %h exp %h", got, exp_v); end
    vectors++;
    if (bus.grant !== 8'h04) begin miscompares++; $display("FAIL areset pre grant got %h exp 04", bus.grant); end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.grant !== 8'h00 || bus.grant_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL areset immediate grant %h valid %0b exp 00 valid 0", bus.grant, bus.grant_valid);
    end
    #2;
    rst_n = 1'b1;
    model_reset();
    bus.req = 8'h36;
    tick();
    got = observe(); exp_v = exp_q.pop_front(); vectors++;
    if (got !== exp_v) begin miscompares++; $display("FAIL areset post sb got %h exp %h", got, exp_v); end
    vectors++;
    if (bus.grant !== 8'h02 || bus.grant_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL areset post grant %h idx %0d exp 02 idx 1", bus.grant, bus.grant_idx);
    end
  endtask

  task automatic test_coincide();
    bus.en  = 1'b1;
    bus.req = 8'h00;
    tick();
    got = observe(); exp_v = exp_q.pop_front(); vectors++;
    if (got !== exp_v) begin miscompares++; $display("FAIL coincide idle sb got %h exp %h", got, exp_v); end
    bus.req = 8'hFF;
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      got = observe(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin miscompares++; $display("FAIL coincide hold sb got %h exp %h", got, exp_v); end
    end
    vectors++;
    if (bus.grant !== 8'h04 || dbg_hold_cnt !== CNT_W'(MAX_HOLD - 1)) begin
      miscompares++;
      $display("FAIL coincide setup grant %h cnt %0d exp 04 cnt %0d", bus.grant, dbg_hold_cnt, MAX_HOLD - 1);
    end
    bus.req = 8'hFB;
    tick();
    got = observe(); exp_v = exp_q.pop_front(); vectors++;
    if (got !== exp_v) begin miscompares++; $display("FAIL coincide switch sb got %h exp %h", got, exp_v); end
    vectors++;
    if (bus.grant !== 8'h08 || bus.expired !== 1'b0) begin
      miscompares++;
      $display("FAIL coincide switch grant %h expired %0b exp 08 expired 0", bus.grant, bus.expired);
    end
    bus.req = 8'h00;
    tick();
    got = observe(); exp_v = exp_q.pop_front(); vectors++;
    if (got !== exp_v) begin miscompares++; $display("FAIL coincide end sb got %h exp %h", got, exp_v); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom_range(0, 255));
      tick();
      got = observe(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin miscompares++; $display("FAIL random sb cyc %0d got %h exp %h", c, got, exp_v); end
      vectors++;
      if ($countones(bus.grant) > 1 || bus.grant_valid !== (|bus.grant) ||
          (bus.grant_valid && bus.grant !== (8'h01 << bus.grant_idx))) begin
        miscompares++;
        $display("FAIL random invariant cyc %0d grant %h idx %0d valid %0b", c, bus.grant, bus.grant_idx, bus.grant_valid);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_grant();
    test_rotation();
    test_sole_expiry();
    test_enable();
    test_async_reset();
    test_coincide();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard leftover got %0d entries exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter8.md
Name: rr_grant_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Issues a registered one-hot grant and its 3-bit binary index, so downstream logic can use either form without a separate decoder stage.
- Enforces a maximum hold time so no requester can starve the others.
- Sits between the 8 request sources and the shared resource's select/enable logic.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles a single grant may be held before forced re-arbitration. Legal range 1..256.
- CNT_W, 8: hold counter width. Must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable. When low, no new grant is issued; an existing grant runs to release or expiry.
- req  input  8  request vector; bit k is requester k, held high while it wants the resource.
- grant  output  8  one-hot grant, registered; all zeros when idle.
- grant_idx  output  3  binary index of the granted requester, registered; holds its last value when idle.
- grant_valid  output  1  high iff grant is non-zero.
- expired  output  1  one-cycle pulse in the cycle after a grant was ended by MAX_HOLD expiry.

Behaviour:
- **Reset (async, rst_n=0):**
  - grant=0, grant_idx=0, grant_valid=0, expired=0, hold_cnt=0, state=IDLE.
  - last_idx=7, so the first search starts at requester 0.
  - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- **Search function pick(start):** scans req[start], req[start+1], ... modulo 8 over all 8 positions and returns the first set bit.
- **State IDLE:**
  - At an edge with en=1 and req!=0: winner w = pick(last_idx+1); grant<=1<<w, grant_idx<=w, last_idx<=w, hold_cnt<=0, state<=GRANT.
  - Otherwise remain in IDLE.
  - Latency is 1 clock from req sampled high to grant high.
- **State GRANT (current index g = grant_idx):**
  - **Keep:** if req[g]=1 and hold_cnt != MAX_HOLD-1, keep the grant and increment hold_cnt.
  - **End condition:** req[g]=0 (release) or hold_cnt = MAX_HOLD-1 (expiry).
  - **On end, with en=1:** w = pick(g+1) over the current req. Because the scan ends at g, g is re-granted only if it is the sole requester.
    - If a winner exists: grant switches to w at this same edge, with no idle gap. hold_cnt<=0, last_idx<=w.
    - If no winner: state<=IDLE and grant<=0.
  - **On end, with en=0:** state<=IDLE and grant<=0.
  - expired<=1 for exactly one cycle when the end cause was expiry. Release takes priority over expiry if both occur in the same cycle, in which case expired stays 0.
- **Simultaneous events:**
  - A request rising in the same cycle another is released is eligible in that cycle's search.
  - Requests dropping while not granted are simply ignored.
- **MAX_HOLD=1:** every granted cycle is an expiry, so the arbiter rotates every cycle among the active requesters.
- **Invariants:**
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - When grant_valid=1, grant == 1<<grant_idx.
  - A requester holding req steadily waits at most 7*MAX_HOLD+1 cycles for a grant.

Test Plan:
- **Reset and first grant:** reset, then req=8'b1000_0001 with en=1. One cycle later grant=8'h01, idx=0. Drop req[0]. Next edge grant=8'h80, idx=7, with no idle cycle in between.
- **Rotation fairness:** req=8'hFF held, MAX_HOLD=4. Grants go 0,1,2,...,7,0, each lasting exactly 4 cycles. expired pulses 8 times per round.
- **Sole requester expiry:** req=8'h10 held, MAX_HOLD=4. Grant stays 8'h10 continuously; expired pulses every 4 cycles; hold_cnt restarts.
- **Enable gating:** en=0 with req=8'h0F gives no grant. Raise en: grant=8'h01. Lower en while granted: the grant holds until req[0] drops, then grant=0 and state returns to IDLE even though req[1..3] are still high.
- **Async reset mid-grant:** with grant=8'h04 active, pulse rst_n low between clock edges. grant=0 and grant_valid=0 immediately. After release the first grant goes to the lowest active index.
- **Release/expiry coincidence:** req[g] drops on the cycle hold_cnt=MAX_HOLD-1. expired stays 0 and the next requester is granted normally.
